// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory
//
// Byte-addressable data memory for the load/store stage of a single-cycle MIPS
// datapath. Word accesses may start at any byte address. Byte order is
// big-endian, so byte Address holds the most significant byte of the word.
// Writes happen on the rising clock edge and reads are combinational.
// Bytes that fall outside the physical storage read as zero, and writes to
// them are dropped. The whole array is cleared by the asynchronous
// active-low reset.
//
// Parameters (the order of the first two is fixed by the datapath, which
// instantiates memory #(32, 32)):
//   DATA_WIDTH  word width in bits, a positive multiple of 8
//   ADDR_WIDTH  width of the byte address bus
//   MEM_BYTES   number of bytes of physical storage
//
// Ports:
//   clk        clock; writes are taken on the rising edge
//   rst_n      asynchronous active-low reset; clears every storage byte
//   Address    byte address of the word access
//   WriteData  word to store
//   MemRead    read enable; ReadData is zero when low
//   MemWrite   write enable
//   ReadData   word read from Address (combinational)
// -----------------------------------------------------------------------------
module memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] ReadData
);

  localparam int BYTES  = DATA_WIDTH / 8;
  // Extra bits beyond ADDR_WIDTH so that Address + (BYTES-1) never wraps.
  // An address near the top of the bus therefore lands out of range and
  // does not alias back onto low memory.
  localparam int IDX_W  = ADDR_WIDTH + $clog2(BYTES) + 1;
  localparam int MEM_AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [IDX_W-1:0] MEM_LIMIT = IDX_W'(MEM_BYTES);

  logic [7:0]       mem_r [MEM_BYTES];
  logic [IDX_W-1:0] idx_s [BYTES];
  logic             ok_s  [BYTES];
  logic [DATA_WIDTH-1:0] read_s;

  // Widened byte index of lane k within the word access.
  function automatic logic [IDX_W-1:0] byte_index(input logic [ADDR_WIDTH-1:0] addr,
                                                  input int k);
    return {{(IDX_W-ADDR_WIDTH){1'b0}}, addr} + IDX_W'(k);
  endfunction

  // Compute per-lane byte indices and their in-range flags.
  always_comb begin
    for (int k = 0; k < BYTES; k++) begin
      idx_s[k] = byte_index(Address, k);
      ok_s[k]  = (idx_s[k] < MEM_LIMIT);
    end
  end

  // Storage array: asynchronous clear, then per-lane big-endian byte writes.
  // Each in-range lane is written on its own, so a write that straddles the
  // top of memory still stores its in-range bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (MemWrite) begin
      for (int k = 0; k < BYTES; k++) begin
        if (ok_s[k]) begin
          mem_r[idx_s[k][MEM_AW-1:0]] <= WriteData[DATA_WIDTH-1-8*k -: 8];
        end
      end
    end
  end

  // Combinational big-endian read, gated by MemRead and by reset.
  always_comb begin
    read_s = '0;
    if (MemRead && rst_n) begin
      for (int k = 0; k < BYTES; k++) begin
        if (ok_s[k]) begin
          read_s[DATA_WIDTH-1-8*k -: 8] = mem_r[idx_s[k][MEM_AW-1:0]];
        end else begin
          read_s[DATA_WIDTH-1-8*k -: 8] = 8'h00;
        end
      end
    end else begin
      read_s = '0;
    end
  end

  assign ReadData = read_s;

endmodule

// File: tb/tb_memory.sv
// -----------------------------------------------------------------------------
// tb_memory
//
// Directed bench for memory #(32, 32, 4096). A byte-array reference model
// tracks storage from the rules: big-endian lanes, out-of-range bytes dropped,
// and asynchronous clear. A compare process checks ReadData against the model
// on every falling clock edge. Directed steps also pin hand-computed literal
// values mid-cycle.
// -----------------------------------------------------------------------------
module tb_memory;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4096;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] ReadData;

  int errors;
  int checks;
  bit started;

  byte unsigned model [MB];

  memory #(DW, AW, MB) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Address  (Address),
    .WriteData(WriteData),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ReadData (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference storage: clear on reset, otherwise store each in-range byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MB; i++) model[i] = 8'h00;
    end else if (MemWrite) begin
      for (int k = 0; k < DW/8; k++) begin
        longint idx;
        idx = longint'(Address) + k;
        if (idx < MB) model[idx] = WriteData[DW-1-8*k -: 8];
      end
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a,
                                               input logic rd, input logic rn);
    logic [DW-1:0] r;
    r = '0;
    if (rd && rn) begin
      for (int k = 0; k < DW/8; k++) begin
        longint idx;
        idx = longint'(a) + k;
        r = r << 8;
        if (idx < MB) r[7:0] = model[idx];
      end
    end
    return r;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      logic [DW-1:0] exp_v;
      exp_v = model_read(Address, MemRead, rst_n);
      checks++;
      if (ReadData !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t addr=%h actual=%h expected=%h",
                 $time, Address, ReadData, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] exp_v);
    checks++;
    if (ReadData !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, ReadData, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemWrite = 1'b1;
    Address = a;
    WriteData = d;
    @(posedge clk);
    #2;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_v,
                    input string name);
    MemRead = 1'b1;
    Address = a;
    #1;
    check(name, exp_v);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    started = 1'b0;
    rst_n = 1'b0;
    Address = '0;
    WriteData = '0;
    MemRead = 1'b0;
    MemWrite = 1'b0;

    // 1. Reset
    do_reset();
    started = 1'b1;
    rd(32'd0,    32'h0000_0000, "reset_a0");
    rd(32'd4,    32'h0000_0000, "reset_a4");
    rd(32'd1000, 32'h0000_0000, "reset_a1000");

    // 2. Aligned writes
    MemRead = 1'b0;
    wr(32'd0, 32'h1122_3344);
    wr(32'd4, 32'h5566_7788);
    rd(32'd0, 32'h1122_3344, "aligned_a0");
    rd(32'd4, 32'h5566_7788, "aligned_a4");
    rd(32'd2, 32'h3344_5566, "unaligned_read_a2");

    // 4. Read gating, no clock needed
    MemRead = 1'b0;
    Address = 32'd0;
    #1;
    check("gate_off", 32'h0000_0000);
    MemRead = 1'b1;
    #1;
    check("gate_on", 32'h1122_3344);

    // 5. Boundary
    wr(32'(MB-2), 32'hAABB_CCDD);
    rd(32'(MB-2), 32'hAABB_0000, "top_straddle");
    rd(32'(MB),   32'h0000_0000, "past_end");
    wr(32'hFFFF_FFFE, 32'h1234_5678);
    rd(32'hFFFF_FFFE, 32'h0000_0000, "bus_top_read");
    rd(32'd0, 32'h1122_3344, "no_wrap_a0");

    // Read-after-write visible right after the edge
    MemRead = 1'b1;
    wr(32'd8, 32'h0BAD_F00D);
    #1;
    check("raw_after_edge", 32'h0BAD_F00D);

    // 3. Overlapping unaligned writes
    do_reset();
    for (int i = 0; i < 5; i++) wr(32'(i), 32'(i + 2));
    rd(32'd0, 32'h0000_0000, "overlap_a0");
    rd(32'd4, 32'h0000_0006, "overlap_a4");
    rd(32'd3, 32'h0000_0000, "overlap_a3");
    rd(32'd1, 32'h0000_0000, "overlap_a1");

    // 6. Async reset mid-operation
    MemRead = 1'b1;
    Address = 32'd4;
    WriteData = 32'hCAFE_F00D;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_write", 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    check("async_clear", 32'h0000_0000);
    @(posedge clk);
    #2;
    MemWrite = 1'b0;
    rst_n = 1'b1;
    rd(32'd4, 32'h0000_0000, "after_reset_a4");
    rd(32'd0, 32'h0000_0000, "after_reset_a0");
    rd(32'd8, 32'h0000_0000, "after_reset_a8");

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Byte-addressable data memory for the single-cycle MIPS datapath (load/store stage).
- Synchronous word writes, combinational word reads, big-endian byte order.
- Contents cleared by an asynchronous active-low reset.
- The datapath instantiates it as memory #(32, 32); positional order of the first two parameters is fixed.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a positive multiple of 8 (BYTES = DATA_WIDTH/8).
- ADDR_WIDTH, 32, width of the byte address bus.
- MEM_BYTES, 4096, number of bytes of physical storage; valid byte addresses are 0 .. MEM_BYTES-1.

Ports:
- clk  input  1  clock; writes occur on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Address  input  ADDR_WIDTH  byte address of the word access (any byte alignment).
- WriteData  input  DATA_WIDTH  word to store.
- MemRead  input  1  read enable.
- MemWrite  input  1  write enable.
- ReadData  output  DATA_WIDTH  word read from Address.

Behaviour:
- Storage: MEM_BYTES bytes. A word access at address A covers bytes A .. A+BYTES-1.
- Byte order is big-endian:
  - byte A holds WriteData[DATA_WIDTH-1 -: 8];
  - byte A+BYTES-1 holds WriteData[7:0].
- Reset (rst_n=0), asynchronous, no clock needed:
  - every storage byte is cleared to 0;
  - held while rst_n=0: writes are ignored and ReadData=0.
- Write:
  - on rising clk with rst_n=1 and MemWrite=1, all BYTES bytes starting at Address are updated in the same edge;
  - no alignment requirement; unaligned writes overwrite overlapping bytes of neighbouring words;
  - with MemWrite=0, no storage change.
- Read:
  - purely combinational, zero latency;
  - MemRead=1: ReadData = big-endian concatenation of bytes Address .. Address+BYTES-1;
  - MemRead=0: ReadData = 0.
- Out of range:
  - any byte index >= MEM_BYTES (including Address near the top of the ADDR_WIDTH space, no wrap-around) reads as 0;
  - writes to such bytes are dropped; the in-range bytes of a straddling write are still written.
- Address arithmetic: byte index computed at ADDR_WIDTH+1 bits or wider, so Address+k never wraps.
- MemRead and MemWrite both 1:
  - ReadData shows pre-edge contents until the edge, then the newly written data (read-after-write visible immediately after the edge);
  - no error condition.
- Reset mid-write: rst_n falling during MemWrite=1 clears memory immediately; an edge while rst_n=0 writes nothing.
- No X propagation: all bytes are defined after the first reset.

Test Plan:
1. Reset: rst_n=0 for 2 cycles, release; MemRead=1, Address=0, 4, 1000 -> ReadData=0x00000000 each.
2. Aligned write/read:
   - MemWrite=1: Address=0 WriteData=0x11223344 on one edge, Address=4 WriteData=0x55667788 on the next edge.
   - Then MemWrite=0, MemRead=1:
     - Address=0 -> 0x11223344.
     - Address=4 -> 0x55667788.
     - Address=2 -> 0x33445566.
3. Overlapping unaligned writes:
   - After reset, write 2,3,4,5,6 at Address 0,1,2,3,4 on consecutive edges.
   - Then read:
     - Address=0 -> 0x00000000.
     - Address=4 -> 0x00000006.
     - Address=3 -> 0x00000000.
     - Address=1 -> 0x00000000.
4. Read gating: MemRead=0 with nonzero contents at Address=0 -> ReadData=0; raising MemRead -> contents appear in the same delta, no clock needed.
5. Boundary:
   - Address=MEM_BYTES-2 write 0xAABBCCDD -> read at MEM_BYTES-2 = 0xAABB0000.
   - Address=MEM_BYTES read -> 0.
   - Address=0xFFFFFFFE write then read -> 0; bytes 0..1 unchanged (no wrap).
6. Async reset mid-operation:
   - MemWrite=1 with data present; pulse rst_n low between edges -> ReadData drops to 0 immediately.
   - Edge during rst_n=0 writes nothing; after release all reads return 0.
